// File: rtl/fetch_ooo_pkg.sv
// Shared definitions for the out-of-order fetch PC sequencer and its next-line BTB.
package fetch_ooo_pkg;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } fetch_state_e;

   localparam int unsigned INSTR_BYTES     = 32'd4;
   localparam int unsigned BTB_OFFSET_BITS = 32'd2;

   function automatic int unsigned btb_tag_width(input int unsigned xlen, input int unsigned index_bits);
      return xlen - index_bits - BTB_OFFSET_BITS;
   endfunction

   function automatic int unsigned btb_entries(input int unsigned index_bits);
      return 32'd1 << index_bits;
   endfunction

endpackage

// File: rtl/nlp_btb_ooo.sv
// Direct-mapped next-line-predictor BTB: combinational lookup, posedge update.
module nlp_btb_ooo
   import fetch_ooo_pkg::*;
#(
   parameter int XLEN           = 64,
   parameter int BTB_INDEX_BITS = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] lookup_pc_i,
   output logic            lookup_hit_o,
   output logic [XLEN-1:0] lookup_target_o,
   input  logic            update_valid_i,
   input  logic [XLEN-1:0] update_pc_i,
   input  logic [XLEN-1:0] update_target_i
);

   localparam int TAG_W   = int'(btb_tag_width(XLEN, BTB_INDEX_BITS));
   localparam int ENTRIES = int'(btb_entries(BTB_INDEX_BITS));
   localparam int IDX_LO  = int'(BTB_OFFSET_BITS);

   logic [ENTRIES-1:0]      valid_q;
   logic [TAG_W-1:0]        tag_q    [ENTRIES];
   logic [XLEN-1:0]         target_q [ENTRIES];

   logic [BTB_INDEX_BITS-1:0] lk_idx_s;
   logic [TAG_W-1:0]          lk_tag_s;
   logic [BTB_INDEX_BITS-1:0] up_idx_s;
   logic [TAG_W-1:0]          up_tag_s;
   logic                      unused_s;

   assign lk_idx_s = lookup_pc_i[BTB_INDEX_BITS+IDX_LO-1:IDX_LO];
   assign lk_tag_s = lookup_pc_i[XLEN-1:BTB_INDEX_BITS+IDX_LO];
   assign up_idx_s = update_pc_i[BTB_INDEX_BITS+IDX_LO-1:IDX_LO];
   assign up_tag_s = update_pc_i[XLEN-1:BTB_INDEX_BITS+IDX_LO];
   // Instruction-offset bits never participate in index or tag.
   assign unused_s = ^{lookup_pc_i[IDX_LO-1:0], update_pc_i[IDX_LO-1:0]};

   assign lookup_hit_o    = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
   assign lookup_target_o = target_q[lk_idx_s];

   // Valid bits are the only state that needs clearing on reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         valid_q <= '0;
      end else if (update_valid_i) begin
         valid_q[up_idx_s] <= 1'b1;
      end
   end

   // Tag/target payload; ignored until the matching valid bit is set.
   always_ff @(posedge clock) begin
      if (reset && update_valid_i) begin
         tag_q[up_idx_s]    <= up_tag_s;
         target_q[up_idx_s] <= update_target_i;
      end
   end

endmodule

// File: rtl/fetch_issue_ooo.sv
// Fetch PC sequencer: issues one PC per fire to the I-cache and fetch_receive_ooo,
// follows the next-line BTB and restarts on back-end redirects.
module fetch_issue_ooo
   import fetch_ooo_pkg::*;
#(
   parameter int              XLEN           = 64,
   parameter logic [XLEN-1:0] RESET_PC       = '0,
   parameter int              BTB_INDEX_BITS = 4
) (
   input  logic            clock,
   input  logic            reset,
   output logic            icache_request_valid,
   input  logic            icache_request_ready,
   output logic [XLEN-1:0] icache_request_PC,
   output logic            fetch_issue_valid,
   input  logic            fetch_issue_ready,
   output logic [XLEN-1:0] fetch_issue_PC,
   output logic            fetch_issue_NLP_BTB_hit,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_PC,
   input  logic            btb_update_valid,
   input  logic [XLEN-1:0] btb_update_PC,
   input  logic [XLEN-1:0] btb_update_target,
   input  logic            halt,
   output logic            flush
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            req_valid_s;
   logic            fire_s;
   logic            flush_s;
   logic            btb_hit_s;
   logic [XLEN-1:0] btb_target_s;

   nlp_btb_ooo #(
      .XLEN           (XLEN),
      .BTB_INDEX_BITS (BTB_INDEX_BITS)
   ) u_btb (
      .clock           (clock),
      .reset           (reset),
      .lookup_pc_i     (pc_q),
      .lookup_hit_o    (btb_hit_s),
      .lookup_target_o (btb_target_s),
      .update_valid_i  (btb_update_valid),
      .update_pc_i     (btb_update_PC),
      .update_target_i (btb_update_target)
   );

   // State and PC registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_RESET;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next state, next PC and issue handshake; redirect beats any same-cycle fire.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_valid_s = 1'b0;
      flush_s     = 1'b0;
      case (state_q)
         ST_RESET: begin
            state_d = redirect_valid ? ST_FLUSH : ST_RUN;
         end
         ST_RUN: begin
            if (redirect_valid) begin
               state_d = ST_FLUSH;
            end else begin
               req_valid_s = fetch_issue_ready & ~halt;
            end
         end
         ST_FLUSH: begin
            flush_s = 1'b1;
            state_d = redirect_valid ? ST_FLUSH : ST_RUN;
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
      fire_s = req_valid_s & icache_request_ready;
      if (redirect_valid) begin
         pc_d = redirect_PC;
      end else if (fire_s) begin
         pc_d = btb_hit_s ? btb_target_s : (pc_q + XLEN'(INSTR_BYTES));
      end else begin
         pc_d = pc_q;
      end
   end

   // Outputs are forced quiet while reset is held, independent of stale state.
   assign icache_request_valid    = reset & req_valid_s;
   assign fetch_issue_valid       = reset & fire_s;
   assign fetch_issue_NLP_BTB_hit = reset & fire_s & btb_hit_s;
   assign flush                   = reset & flush_s;
   assign icache_request_PC       = (reset & req_valid_s) ? pc_q : '0;
   assign fetch_issue_PC          = (reset & req_valid_s) ? pc_q : '0;

endmodule

// File: tb/tb_fetch_issue_ooo.sv
// Randomized and directed self-checking bench for fetch_issue_ooo against a behavioural model.
module tb_fetch_issue_ooo;

   localparam int          XLEN     = 64;
   localparam logic [63:0] RST_PC   = 64'h100;
   localparam int          IDX_BITS = 4;

   logic        clock = 1'b0;
   logic        reset, icache_request_ready, fetch_issue_ready, redirect_valid;
   logic        btb_update_valid, halt;
   logic [63:0] redirect_PC, btb_update_PC, btb_update_target;
   logic        icache_request_valid, fetch_issue_valid, fetch_issue_NLP_BTB_hit, flush;
   logic [63:0] icache_request_PC, fetch_issue_PC;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: expected PC, "first cycle after reset", pending flush, BTB contents.
   logic [63:0] m_pc;
   bit          m_boot;
   bit          m_flush;
   bit          m_bv  [16];
   logic [57:0] m_btag[16];
   logic [63:0] m_btgt[16];

   always #5 clock = ~clock;

   fetch_issue_ooo #(.XLEN(XLEN), .RESET_PC(RST_PC), .BTB_INDEX_BITS(IDX_BITS)) dut (
      .clock                   (clock),
      .reset                   (reset),
      .icache_request_valid    (icache_request_valid),
      .icache_request_ready    (icache_request_ready),
      .icache_request_PC       (icache_request_PC),
      .fetch_issue_valid       (fetch_issue_valid),
      .fetch_issue_ready       (fetch_issue_ready),
      .fetch_issue_PC          (fetch_issue_PC),
      .fetch_issue_NLP_BTB_hit (fetch_issue_NLP_BTB_hit),
      .redirect_valid          (redirect_valid),
      .redirect_PC             (redirect_PC),
      .btb_update_valid        (btb_update_valid),
      .btb_update_PC           (btb_update_PC),
      .btb_update_target       (btb_update_target),
      .halt                    (halt),
      .flush                   (flush)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // One cycle: drive at negedge, check combinational outputs, then advance the model.
   task automatic step(input logic r, input logic rdy, input logic icr, input logic h,
                       input logic rv, input logic [63:0] rpc,
                       input logic uv, input logic [63:0] upc, input logic [63:0] utg);
      bit e_req, e_fire, e_hit, e_flush;
      logic [63:0] e_tgt;
      int idx;
      @(negedge clock);
      reset = r; fetch_issue_ready = rdy; icache_request_ready = icr; halt = h;
      redirect_valid = rv; redirect_PC = rpc;
      btb_update_valid = uv; btb_update_PC = upc; btb_update_target = utg;
      #1;
      idx   = int'(m_pc[5:2]);
      e_hit = m_bv[idx] && (m_btag[idx] == m_pc[63:6]);
      e_tgt = m_btgt[idx];
      e_req = r && !m_boot && !m_flush && rdy && !h && !rv;
      e_fire  = e_req && icr;
      e_flush = r && !m_boot && m_flush;
      check_val("req_valid", {63'd0, icache_request_valid}, {63'd0, e_req});
      check_val("issue_valid", {63'd0, fetch_issue_valid}, {63'd0, e_fire});
      check_val("flush", {63'd0, flush}, {63'd0, e_flush});
      check_val("btb_hit", {63'd0, fetch_issue_NLP_BTB_hit}, {63'd0, e_fire && e_hit});
      if (e_req) check_val("req_pc", icache_request_PC, m_pc);
      if (e_fire) check_val("issue_pc", fetch_issue_PC, m_pc);
      if (!r) begin
         m_pc = RST_PC; m_boot = 1'b1; m_flush = 1'b0;
         for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
      end else begin
         if (rv) m_pc = rpc;
         else if (e_fire) m_pc = e_hit ? e_tgt : m_pc + 64'd4;
         m_flush = rv;
         m_boot  = 1'b0;
         if (uv) begin
            m_bv[int'(upc[5:2])]   = 1'b1;
            m_btag[int'(upc[5:2])] = upc[63:6];
            m_btgt[int'(upc[5:2])] = utg;
         end
      end
   endtask

   task automatic run(input logic rdy, input logic icr);
      step(1'b1, rdy, icr, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
   endtask

   task automatic redir(input logic [63:0] rpc);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, rpc, 1'b0, 64'd0, 64'd0);
   endtask

   initial begin
      logic r, rdy, icr, h, rv, uv;
      logic [63:0] rpc, upc, utg;
      m_pc = RST_PC; m_boot = 1'b1; m_flush = 1'b0;
      for (int i = 0; i < 16; i++) begin
         m_bv[i] = 1'b0; m_btag[i] = 58'd0; m_btgt[i] = 64'd0;
      end
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
      run(1'b1, 1'b1);
      check_val("boot_quiet", {63'd0, fetch_issue_valid}, 64'd0);
      run(1'b1, 1'b1); check_val("plan_pc0", fetch_issue_PC, 64'h100);
      run(1'b1, 1'b1); check_val("plan_pc1", fetch_issue_PC, 64'h104);
      run(1'b1, 1'b1); check_val("plan_pc2", fetch_issue_PC, 64'h108);
      for (int i = 0; i < 3; i++) run(1'b0, 1'b1);
      run(1'b1, 1'b1); check_val("plan_hold_pc", fetch_issue_PC, 64'h10C);
      for (int i = 0; i < 3; i++) begin
         run(1'b1, 1'b0);
         check_val("plan_stall_req", {63'd0, icache_request_valid}, 64'd1);
      end
      run(1'b1, 1'b1); check_val("plan_stall_pc", fetch_issue_PC, 64'h110);
      redir(64'h2000);
      run(1'b1, 1'b1); check_val("plan_flush", {63'd0, flush}, 64'd1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 64'h2008, 64'h3000);
      check_val("plan_redir_pc", fetch_issue_PC, 64'h2000);
      run(1'b1, 1'b1); check_val("plan_redir_pc1", fetch_issue_PC, 64'h2004);
      run(1'b1, 1'b1); check_val("plan_btb_hit", {63'd0, fetch_issue_NLP_BTB_hit}, 64'd1);
      run(1'b1, 1'b1); check_val("plan_btb_tgt", fetch_issue_PC, 64'h3000);
      redir(64'h400);
      redir(64'h500);
      run(1'b1, 1'b1); check_val("plan_flush2", {63'd0, flush}, 64'd1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 64'h508, 64'h900);
      check_val("plan_b2b_pc", fetch_issue_PC, 64'h500);
      run(1'b1, 1'b1);
      run(1'b1, 1'b1); check_val("plan_hit_508", {63'd0, fetch_issue_NLP_BTB_hit}, 64'd1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 1'b1, 64'h104, 64'h700);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
      run(1'b1, 1'b1);
      run(1'b1, 1'b1); check_val("plan_rst_pc", fetch_issue_PC, 64'h100);
      run(1'b1, 1'b1); check_val("plan_rst_upd_ignored", fetch_issue_PC, 64'h104);
      redir(64'h508);
      run(1'b1, 1'b1);
      run(1'b1, 1'b1); check_val("plan_btb_cleared", {63'd0, fetch_issue_NLP_BTB_hit}, 64'd0);
      redir(64'hFFFF_FFFF_FFFF_FFFC);
      run(1'b1, 1'b1);
      run(1'b1, 1'b1);
      run(1'b1, 1'b1); check_val("plan_wrap", fetch_issue_PC, 64'h0);
      for (int n = 0; n < 3000; n++) begin
         r   = ($urandom_range(0, 99) != 0);
         rdy = ($urandom_range(0, 9) < 8);
         icr = ($urandom_range(0, 9) < 8);
         h   = ($urandom_range(0, 9) == 0);
         rv  = ($urandom_range(0, 19) == 0);
         rpc = 64'h1000 + 64'($urandom_range(0, 255)) * 64'd4;
         uv  = ($urandom_range(0, 6) == 0);
         upc = m_pc + 64'($urandom_range(0, 6)) * 64'd4;
         utg = 64'h1000 + 64'($urandom_range(0, 255)) * 64'd4;
         step(r, rdy, icr, h, rv, rpc, uv, upc, utg);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_issue_ooo.md
Name: fetch_issue_ooo

Overview:
PC sequencer and issue controller for the out-of-order fetch stage. It generates fetch PCs and issues each one to the I-cache request port and to fetch_receive_ooo in the same cycle. Issue is gated by fetch_receive_ooo slot availability (fetch_issue_ready) and I-cache readiness. It owns a small next-line-predictor BTB and handles redirects by flushing fetch_receive_ooo and restarting from the redirect PC.

Parameters:
XLEN, 64, address/PC width
RESET_PC, 0, first PC fetched after reset
BTB_INDEX_BITS, 4, log2 of BTB entries (direct-mapped)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset (asserted when 0)
icache_request_valid  output  1  fetch request to I-cache
icache_request_ready  input  1  I-cache accepts request this cycle
icache_request_PC  output  XLEN  PC of I-cache request
fetch_issue_valid  output  1  PC handed to fetch_receive_ooo
fetch_issue_ready  input  1  fetch_receive_ooo has a free slot
fetch_issue_PC  output  XLEN  same value as icache_request_PC
fetch_issue_NLP_BTB_hit  output  1  BTB hit for the issued PC
redirect_valid  input  1  back-end redirect (mispredict/trap)
redirect_PC  input  XLEN  new fetch PC
btb_update_valid  input  1  write a BTB entry
btb_update_PC  input  XLEN  branch PC to install
btb_update_target  input  XLEN  branch target to install
halt  input  1  suppress new fetches; hold PC
flush  output  1  one-cycle flush to fetch_receive_ooo

Behaviour:
- Reset (reset==0 at posedge): PC<=RESET_PC; state<=RESET; all BTB valid bits cleared. While in reset, and in the first cycle after it, all outputs are 0.
- States:
  - RESET -> RUN: unconditional next cycle; a redirect here goes to FLUSH.
  - RUN -> FLUSH: on redirect_valid.
  - FLUSH -> RUN: next cycle unless redirect_valid again.
- icache_request_valid = (state==RUN) & fetch_issue_ready & !halt & !redirect_valid. It never depends on icache_request_ready.
- fetch_issue_valid = icache_request_valid & icache_request_ready. This is the "fire" condition; exactly one PC is consumed per fire.
- icache_request_PC = fetch_issue_PC = PC register, driven whenever valid.
- On fire: PC <= btb_hit ? btb_target : PC+4. The addition wraps modulo 2^XLEN. fetch_issue_NLP_BTB_hit = btb_hit in the fire cycle, else 0.
- No fire: PC holds. This covers halt, FR full and I-cache stall.
- Redirect:
  - At the posedge with redirect_valid: PC<=redirect_PC, state<=FLUSH.
  - In FLUSH, flush=1 for exactly one cycle and no request is issued.
  - Redirect has priority over a same-cycle fire: no issue occurs in that cycle.
  - Redirect while in FLUSH: PC takes the newest redirect_PC and flush stays high one more cycle.
  - flush is 0 in all other states.
- BTB:
  - 2^BTB_INDEX_BITS entries; index = PC[BTB_INDEX_BITS+1:2]; tag = PC[XLEN-1:BTB_INDEX_BITS+2].
  - Each entry holds {valid, tag, target}. Lookup is combinational on the PC register.
  - hit = valid & tag match.
  - An update writes at the posedge, so a same-cycle lookup of the same index sees the old contents.
  - An update during reset is ignored.
- halt during FLUSH: flush still pulses; PC holds the redirect PC until halt drops.

Decomposition:
- Shared package fetch_ooo_pkg holds:
  - fetch state encoding (RESET, RUN, FLUSH)
  - instruction byte increment (4)
  - BTB entry field widths, derived from XLEN and BTB_INDEX_BITS
- One sub-module, nlp_btb_ooo: direct-mapped BTB with combinational lookup port and synchronous update port. Parameters XLEN and BTB_INDEX_BITS; same clock/reset.

Test Plan:
- Reset, RESET_PC=0x100; fetch_issue_ready=1, icache_request_ready=1 -> fetch_issue_valid=0 in the first cycle. Then three consecutive issues with PC 0x100, 0x104, 0x108; NLP_BTB_hit=0; flush=0.
- fetch_issue_ready=0 for 3 cycles mid-stream at PC 0x10C -> no valid for 3 cycles. Then 0x10C is issued once and never skipped. Repeat with icache_request_ready=0: icache_request_valid stays 1, fetch_issue_valid stays 0.
- redirect_valid with redirect_PC=0x2000 in a ready cycle -> no issue that cycle; flush=1 the next cycle only. The following cycle issues 0x2000, then 0x2004.
- BTB update PC=0x2008 target=0x3000 while fetching 0x2000 -> the issue of 0x2008 has NLP_BTB_hit=1. The next issued PC is 0x3000, with hit=0 at 0x3000.
- Back-to-back redirects to 0x400 then 0x500 -> flush high for 2 cycles; first issued PC is 0x500.
- reset low mid-stream with halt=1 -> outputs 0 and BTB cleared. After release: fetch resumes at RESET_PC and the earlier BTB entry no longer hits.
